platform_scheduler: RTL and testbench
=====================================

# platform_scheduler

Per-frame sequencer that owns the 8-entry platform position table and updates it one slot per clock after each frame edge. Applies a vertical scroll amount supplied by the player/camera logic, wraps platforms that leave the bottom of the screen back to the top, and respawns their X position from an on-chip LFSR. It also loads the start-of-game layout whenever the game enters the menu state. Its outputs feed the platform renderer and the collision logic directly.

## Interface
- `N`, 8, number of platform slots; fixed at 8.
- `H`, 240, screen height in pixels; valid Y is 0..H-1.
- `X_min`, 70, leftmost legal platform X.
- `X_max`, 249, rightmost legal pixel of any platform.
- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk_edge`  in  2  frame-clock edge code; `2'b01` is a frame start.
- `state`  in  8  game state: 0 = menu/init, 1 = play, any other value = frozen.
- `scroll`  in  4  downward scroll in pixels for this frame; sampled on the frame start.
- `platform_size`  in  8  platform width in pixels.
- `Platform_X_out [0:7]`  out  10 each  platform left X.
- `Platform_Y_out [0:7]`  out  10 each  platform top Y.
- `busy`  out  1  high while in INIT or SCAN.
- `frame_done`  out  1  one-cycle pulse when a SCAN completes.
- `overrun`  out  1  sticky; set when a frame start is dropped.
- `respawn_count`  out  16  total platform wraps, saturating.

## Operation
- FSM states: IDLE, INIT, SCAN, DONE. A 3-bit slot counter `i` is used in INIT and SCAN.
- Reset values:
  - All X/Y outputs 0, `busy`, `frame_done`, `overrun` and `respawn_count` 0.
  - FSM in IDLE, `i` = 0.
  - LFSR = 16'hACE1; `prev_state` = 8'hFF, so the block initialises at the first `state` = 0 after reset.
- LFSR: 16-bit Galois, mask 16'hB400 (shift right; XOR the mask when the shifted-out bit is 1). It advances every clock, including during Reset release and in every FSM state.
- IDLE → INIT when `state` == 0 and `prev_state` != 0. `prev_state` registers `state` every clock.
- INIT writes slot `i` in the cycle `i` = 0..7, then goes to IDLE.
  - Default X = {140,180,220,160,70,140,80,120}.
  - Default Y = {0,30,60,90,120,150,180,210}.
  - INIT also clears `overrun`. It does not clear `respawn_count`; only Reset does.
- IDLE → SCAN when `frame_clk_edge` == 2'b01 and `state` == 1. `scroll` is latched into `scroll_q` in the same cycle.
- SCAN, one slot per cycle, `i` = 0..7. Compute `y_sum` = Y[i] + `scroll_q` in 11 bits.
  - If `y_sum` <= H-1: Y[i] = `y_sum`; X[i] is unchanged.
  - Otherwise (wrap): Y[i] = `y_sum` - H, which keeps the vertical spacing.
  - On wrap, X[i] = X_min + `off`:
    - `range` = X_max - X_min + 1 - `platform_size` (signed, 11 bits).
    - If `range` <= 0, `off` = 0.
    - Otherwise `off` = LFSR[7:0] reduced by at most two conditional subtractions of `range`. If the result is still >= `range`, `off` = `range` - 1.
    - The LFSR value used is the one present in that slot's cycle.
  - On wrap, `respawn_count` += 1, saturating at 16'hFFFF.
- After slot 7: SCAN → DONE. DONE pulses `frame_done` for one cycle, then returns to IDLE.
- A frame start that arrives while in INIT, SCAN or DONE is dropped and sets `overrun`. A frame start in IDLE with `state` not equal to 1 is ignored and does not set `overrun`.
- If `state` changes during SCAN, the scan still completes. A transition to `state` 0 is acted on from IDLE afterwards, via `prev_state` edge detection captured into a pending bit.
- Reset in any state: all registers return to their reset values on the next edge. Nothing partial is preserved.

## Timing
- Frame start sampled at edge T:
  - `busy` = 1 from T+1.
  - Slot `i` output is updated at edge T+1+`i`.
  - `frame_done` = 1 during T+9 to T+10.
  - `busy` = 0 from T+9, i.e. whenever the FSM is in DONE or IDLE.
- Init sampled at edge T (`state` becomes 0): slot `i` is written at edge T+1+`i`, and the FSM is back in IDLE after T+8.
- A full frame cycle is 10 clocks, far below one frame period.
- Outputs are fully registered. Unscanned slots hold their values mid-scan, so other slots may show old values during SCAN.

## Test plan
- Reset, then hold `state` = 3 for 20 cycles → all outputs 0, `busy` = 0, no `frame_done`.
- Reset, set `state` = 0 → slots 0..7 loaded with the default X/Y on 8 consecutive edges; `busy` is high exactly 8 cycles.
- After init, `state` = 1, `scroll` = 5, one frame edge → Y = {5,35,...,215}, X unchanged, `frame_done` pulses 9 cycles after the edge, `respawn_count` = 0.
- Slot 7 at Y = 235 with `scroll` = 10 → Y7 = 5, X7 equal to the model value computed from the LFSR at that cycle, `respawn_count` = 1. With `platform_size` = 200, X7 = 70.
- Second frame edge 3 cycles after the first → ignored, `overrun` = 1, table equals the single-frame result; a subsequent init clears `overrun`.
- Reset asserted at SCAN slot 4 → next cycle all outputs 0, FSM in IDLE, `busy` = 0.

Source files
------------

// File: rtl/platform_scheduler.sv
// platform_scheduler
//
// Owns the 8-entry platform position table. After each frame start it walks the
// table one slot per clock: it adds the latched scroll amount to each Y, and it
// wraps any platform that falls off the bottom of the screen back to the top.
// A wrapped platform gets a new X position taken from a free-running LFSR.
// Entering the menu state (state == 0) reloads the start-of-game layout.
//
// Ports
//   Clk             system clock
//   Reset           synchronous, active-high reset
//   frame_clk_edge  frame-clock edge code; 2'b01 marks a frame start
//   state           game state: 0 = menu/init, 1 = play, other values = frozen
//   scroll          downward scroll in pixels, latched on an accepted frame start
//   platform_size   platform width in pixels; bounds the respawn X range
//   Platform_X_out  per-slot platform left X
//   Platform_Y_out  per-slot platform top Y
//   busy            high while a table init or a scan is in progress (registered)
//   frame_done      one-cycle pulse after a scan completes
//   overrun         sticky; a frame start arrived while busy and was dropped
//   respawn_count   saturating count of platform wraps

module platform_scheduler (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  frame_clk_edge,
    input  logic [7:0]  state,
    input  logic [3:0]  scroll,
    input  logic [7:0]  platform_size,
    output logic [9:0]  Platform_X_out [0:7],
    output logic [9:0]  Platform_Y_out [0:7],
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic [15:0] respawn_count
);

    localparam logic [10:0] ScreenH   = 11'd240;
    localparam logic [10:0] XMin      = 11'd70;
    localparam logic [10:0] XSpan     = 11'd180;  // X_max - X_min + 1
    localparam logic [15:0] LfsrSeed  = 16'hACE1;
    localparam logic [15:0] LfsrMask  = 16'hB400;

    typedef enum logic [1:0] {StIdle, StInit, StScan, StDone} fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [2:0]  i_q, i_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  prev_state_q;
    logic        init_pend_q, init_pend_d;
    logic [3:0]  scroll_q;
    logic [9:0]  x_q [0:7];
    logic [9:0]  y_q [0:7];

    logic        frame_start;
    logic        init_edge;
    logic        go_init;
    logic        go_scan;

    logic [10:0]        y_sum;
    logic               wrap;
    logic [9:0]         y_new;
    logic signed [10:0] range_s;
    logic [10:0]        range_u;
    logic [10:0]        off_v0, off_v1, off_v2, off;
    logic [9:0]         x_new;

    function automatic logic [9:0] def_x(input logic [2:0] idx);
        logic [9:0] v;
        case (idx)
            3'd0:    v = 10'd140;
            3'd1:    v = 10'd180;
            3'd2:    v = 10'd220;
            3'd3:    v = 10'd160;
            3'd4:    v = 10'd70;
            3'd5:    v = 10'd140;
            3'd6:    v = 10'd80;
            default: v = 10'd120;
        endcase
        return v;
    endfunction

    assign Platform_X_out = x_q;
    assign Platform_Y_out = y_q;

    // Galois LFSR, shift right; runs every clock regardless of FSM state.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    end

    // Per-slot scroll/wrap/respawn datapath for the slot selected by i_q.
    always_comb begin
        y_sum   = {1'b0, y_q[i_q]} + {7'd0, scroll_q};
        wrap    = y_sum > (ScreenH - 11'd1);
        y_new   = wrap ? 10'(y_sum - ScreenH) : y_sum[9:0];
        range_s = $signed(XSpan) - $signed({3'b000, platform_size});
        range_u = range_s;
        // Bounded modulo: two conditional subtractions, then clamp to range-1.
        off_v0  = {3'b000, lfsr_q[7:0]};
        off_v1  = (off_v0 >= range_u) ? off_v0 - range_u : off_v0;
        off_v2  = (off_v1 >= range_u) ? off_v1 - range_u : off_v1;
        if (range_s <= 11'sd0) begin
            off = 11'd0;
        end else if (off_v2 >= range_u) begin
            off = range_u - 11'd1;
        end else begin
            off = off_v2;
        end
        x_new = 10'(XMin + off);
    end

    always_comb begin
        frame_start = frame_clk_edge == 2'b01;
        init_edge   = (state == 8'd0) && (prev_state_q != 8'd0);
        fsm_d       = fsm_q;
        i_d         = i_q;
        go_init     = 1'b0;
        go_scan     = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (init_edge || init_pend_q) begin
                    fsm_d   = StInit;
                    i_d     = 3'd0;
                    go_init = 1'b1;
                end else if (frame_start && state == 8'd1) begin
                    fsm_d   = StScan;
                    i_d     = 3'd0;
                    go_scan = 1'b1;
                end
            end
            StInit: begin
                i_d = i_q + 3'd1;
                if (i_q == 3'd7) fsm_d = StIdle;
            end
            StScan: begin
                i_d = i_q + 3'd1;
                if (i_q == 3'd7) fsm_d = StDone;
            end
            StDone: begin
                fsm_d = StIdle;
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
        // A menu entry seen while busy is remembered until IDLE can act on it.
        init_pend_d = (init_pend_q || init_edge) && !go_init;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsm_q         <= StIdle;
            i_q           <= 3'd0;
            lfsr_q        <= LfsrSeed;
            prev_state_q  <= 8'hFF;
            init_pend_q   <= 1'b0;
            scroll_q      <= 4'd0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            respawn_count <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                x_q[k] <= 10'd0;
                y_q[k] <= 10'd0;
            end
        end else begin
            fsm_q        <= fsm_d;
            i_q          <= i_d;
            lfsr_q       <= lfsr_d;
            prev_state_q <= state;
            init_pend_q  <= init_pend_d;
            busy         <= (fsm_q == StInit) || (fsm_q == StScan);
            frame_done   <= fsm_q == StDone;

            if (go_scan) scroll_q <= scroll;

            if (go_init) begin
                overrun <= 1'b0;
            end else if (frame_start && fsm_q != StIdle) begin
                overrun <= 1'b1;
            end

            if (fsm_q == StInit) begin
                x_q[i_q] <= def_x(i_q);
                y_q[i_q] <= {7'd0, i_q} * 10'd30;
            end

            if (fsm_q == StScan) begin
                y_q[i_q] <= y_new;
                if (wrap) begin
                    x_q[i_q] <= x_new;
                    if (respawn_count != 16'hFFFF) respawn_count <= respawn_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_platform_scheduler.sv
// Directed bench for platform_scheduler: reset/frozen behaviour, table init,
// scrolling, wrap with respawn X, dropped frame starts and mid-scan reset.

module tb_platform_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  frame_clk_edge;
    logic [7:0]  state;
    logic [3:0]  scroll;
    logic [7:0]  platform_size;
    logic [9:0]  px [0:7];
    logic [9:0]  py [0:7];
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [15:0] respawn_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  exp_x_tab [0:7];
    logic [9:0]  exp_y_tab [0:7];
    logic [15:0] m_lfsr;
    logic [15:0] last_lfsr_t;

    localparam int DefX [8] = '{140, 180, 220, 160, 70, 140, 80, 120};

    platform_scheduler dut (
        .Clk            (clk),
        .Reset          (rst),
        .frame_clk_edge (frame_clk_edge),
        .state          (state),
        .scroll         (scroll),
        .platform_size  (platform_size),
        .Platform_X_out (px),
        .Platform_Y_out (py),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun),
        .respawn_count  (respawn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR tracking the DUT's free-running generator.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic int model_x(input logic [15:0] l, input int size);
        int rng;
        int v;
        rng = 180 - size;
        if (rng <= 0) return 70;
        v = int'(l[7:0]);
        if (v >= rng) v = v - rng;
        if (v >= rng) v = v - rng;
        if (v >= rng) v = rng - 1;
        return 70 + v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_table(input string tag);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("%s_x%0d", tag, k), 32'(px[k]), 32'(exp_x_tab[k]));
            check_eq($sformatf("%s_y%0d", tag, k), 32'(py[k]), 32'(exp_y_tab[k]));
        end
    endtask

    task automatic set_default_table();
        for (int k = 0; k < 8; k++) begin
            exp_x_tab[k] = 10'(DefX[k]);
            exp_y_tab[k] = 10'(30 * k);
        end
    endtask

    // state -> 0 sampled at edge T; slot k written at T+1+k.
    task automatic do_init(input string tag);
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        state = 8'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);  // T + k + 0.5
            if (busy) busy_cnt++;
            if (k >= 1 && k <= 8) begin
                check_eq($sformatf("%s_slot%0d_x", tag, k - 1), 32'(px[k-1]), 32'(DefX[k-1]));
                check_eq($sformatf("%s_slot%0d_y", tag, k - 1), 32'(py[k-1]), 32'(30 * (k - 1)));
            end
        end
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
        set_default_table();
        check_table(tag);
        state = 8'd1;
    endtask

    // Frame start sampled at edge T; optional second start at T+3.
    task automatic do_frame(input string tag, input logic [3:0] s, input bit dup);
        @(negedge clk);
        frame_clk_edge = 2'b01;
        scroll         = s;
        @(negedge clk);  // T+0.5
        frame_clk_edge = 2'b00;
        last_lfsr_t    = m_lfsr;
        @(negedge clk);  // T+1.5
        check_eq({tag, "_busy_t1"}, 32'(busy), 32'd1);
        @(negedge clk);  // T+2.5
        if (dup) frame_clk_edge = 2'b01;
        @(negedge clk);  // T+3.5
        frame_clk_edge = 2'b00;
        repeat (5) @(negedge clk);  // T+8.5
        check_eq({tag, "_fd_t8"}, 32'(frame_done), 32'd0);
        @(negedge clk);  // T+9.5
        check_eq({tag, "_fd_t9"}, 32'(frame_done), 32'd1);
        check_eq({tag, "_busy_t9"}, 32'(busy), 32'd0);
        @(negedge clk);  // T+10.5
        check_eq({tag, "_fd_t10"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int fd_seen;
        int busy_seen;
        logic [15:0] l;

        rst            = 1'b1;
        frame_clk_edge = 2'b00;
        state          = 8'd3;
        scroll         = 4'd0;
        platform_size  = 8'd40;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Frozen state: nothing moves; a frame start is ignored without overrun.
        fd_seen   = 0;
        busy_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            frame_clk_edge = (k == 5) ? 2'b01 : 2'b00;
            if (frame_done) fd_seen++;
            if (busy) busy_seen++;
        end
        frame_clk_edge = 2'b00;
        check_eq("frozen_frame_done", 32'(fd_seen), 32'd0);
        check_eq("frozen_busy", 32'(busy_seen), 32'd0);
        check_eq("frozen_overrun", 32'(overrun), 32'd0);
        check_eq("frozen_respawn", 32'(respawn_count), 32'd0);
        for (int k = 0; k < 8; k++) begin
            exp_x_tab[k] = 10'd0;
            exp_y_tab[k] = 10'd0;
        end
        check_table("reset");

        do_init("init1");

        // Scroll 5 with a dropped second frame start.
        do_frame("f1", 4'd5, 1'b1);
        for (int k = 0; k < 8; k++) exp_y_tab[k] = 10'(5 + 30 * k);
        check_table("f1");
        check_eq("f1_overrun", 32'(overrun), 32'd1);
        check_eq("f1_respawn", 32'(respawn_count), 32'd0);

        do_frame("f2", 4'd10, 1'b0);
        do_frame("f3", 4'd10, 1'b0);

        // Slot 7 at 235 + 10 wraps to 5; range <= 0 pins X to X_min.
        platform_size = 8'd200;
        do_frame("f4", 4'd10, 1'b0);
        for (int k = 0; k < 7; k++) exp_y_tab[k] = 10'(35 + 30 * k);
        exp_y_tab[7] = 10'd5;
        exp_x_tab[7] = 10'd70;
        check_table("f4");
        check_eq("f4_respawn", 32'(respawn_count), 32'd1);

        platform_size = 8'd40;
        do_frame("f5", 4'd15, 1'b0);
        for (int k = 0; k < 8; k++) exp_y_tab[k] = (k == 7) ? 10'd20 : 10'(50 + 30 * k);
        check_table("f5");

        // Slot 6 at 230 + 15 wraps to 5; X from the LFSR in slot 6's cycle.
        do_frame("f6", 4'd15, 1'b0);
        l = last_lfsr_t;
        repeat (6) l = lfsr_step(l);
        for (int k = 0; k < 6; k++) exp_y_tab[k] = 10'(65 + 30 * k);
        exp_y_tab[6] = 10'd5;
        exp_y_tab[7] = 10'd35;
        exp_x_tab[6] = 10'(model_x(l, 40));
        check_table("f6");
        check_eq("f6_respawn", 32'(respawn_count), 32'd2);
        check_eq("f6_overrun_sticky", 32'(overrun), 32'd1);

        // Re-init clears overrun but keeps respawn_count.
        do_init("init2");
        check_eq("init2_respawn", 32'(respawn_count), 32'd2);

        // Reset during scan slot 4.
        @(negedge clk);
        frame_clk_edge = 2'b01;
        scroll         = 4'd5;
        @(negedge clk);  // T+0.5
        frame_clk_edge = 2'b00;
        repeat (4) @(negedge clk);  // T+4.5
        check_eq("midscan_y0", 32'(py[0]), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_x_tab[k] = 10'd0;
            exp_y_tab[k] = 10'd0;
        end
        check_table("rst_scan");
        check_eq("rst_scan_busy", 32'(busy), 32'd0);
        check_eq("rst_scan_respawn", 32'(respawn_count), 32'd0);
        check_eq("rst_scan_overrun", 32'(overrun), 32'd0);
        fd_seen   = 0;
        busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (frame_done) fd_seen++;
            if (busy) busy_seen++;
        end
        check_eq("rst_scan_no_fd", 32'(fd_seen), 32'd0);
        check_eq("rst_scan_no_busy", 32'(busy_seen), 32'd0);
        check_table("rst_scan_hold");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
